sram_load_sequencer: RTL
========================

// Module: sram_load_sequencer
// PURPOSE
//   Host-side initiator for the compute DUT's SRAM/run protocol. Streams a job image
//   (word0 = number of inputs, word1 = size of inputs, then packed data) into input SRAM
//   from address 0, then raises dut_run and waits for the dut_busy rise/fall.
//   It then reads result_count result words from RESULT_BASE and streams them back out.
//   Sits between the host link and the SRAM write/read ports opposite the DUT.
// PARAMETERS
//   ADDR_W       12      SRAM address width
//   DATA_W       16      SRAM/stream word width
//   RESULT_BASE  12'h800 first result address read back after DUT completes
//   LOAD_MAX     12'h7FF highest legal load address; words past it are dropped
//   TIMEOUT_CYC  65535   watchdog limit in cycles (LOADER_TIMEOUT_EN only)
// PORTS
//   clk                    in   1       clock
//   reset_b                in   1       asynchronous active-low reset
//   host_in_valid          in   1       load word valid
//   host_in_ready          out  1       load word accepted when valid&ready
//   host_in_data           in   DATA_W  load word
//   host_in_last           in   1       marks final load word of the job
//   result_count           in   ADDR_W  result words to return; sampled on first load beat
//   ld_sram_write_address  out  ADDR_W  input SRAM write address
//   ld_sram_write_data     out  DATA_W  input SRAM write data
//   ld_sram_write_enable   out  1       write strobe, one cycle per word
//   dut_run                out  1       start request to DUT
//   dut_busy               in   1       DUT computing
//   ld_sram_read_address   out  ADDR_W  result SRAM read address
//   sram_ld_read_data      in   DATA_W  result data, valid 1 cycle after address
//   host_out_valid         out  1       result word valid
//   host_out_ready         in   1       host accepts result
//   host_out_data          out  DATA_W  result word
//   host_out_last          out  1       with final result word
//   job_done               out  1       one-cycle pulse after last result accepted
//   load_overflow          out  1       sticky: load word dropped past LOAD_MAX; cleared in IDLE on new job
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; address/count registers 0. Async assert, sync deassert.
//   States: IDLE -> LOAD -> RUN -> WAIT_DONE -> RD_ADDR -> RD_DATA -> OUT_HOLD -> (RD_ADDR|FINISH) -> IDLE.
//   IDLE: host_in_ready=1; first accepted beat writes addr 0, latches result_count, clears
//         load_overflow, enters LOAD (or RUN if host_in_last on that beat).
//   LOAD: host_in_ready=1; each accepted beat -> write_enable=1 next cycle, addr=previous+1.
//         Address > LOAD_MAX: no write, load_overflow<=1, address does not wrap.
//         Accepted beat with host_in_last -> RUN.
//   RUN: host_in_ready=0; dut_run=1 held until dut_busy sampled 1, then dut_run=0 -> WAIT_DONE.
//   WAIT_DONE: wait for dut_busy==0 -> RD_ADDR (result_count==0: go straight to FINISH).
//   RD_ADDR: drive ld_sram_read_address=RESULT_BASE+idx -> RD_DATA.
//   RD_DATA: capture sram_ld_read_data into host_out_data, host_out_valid=1 -> OUT_HOLD.
//   OUT_HOLD: hold data/valid stable until host_out_ready; host_out_last=1 when idx==result_count-1.
//             On handshake: idx++, next RD_ADDR, or FINISH after last.
//   FINISH: job_done=1 for one cycle -> IDLE.
//   Result throughput: one word per 3 cycles with host_out_ready tied high.
//   RESULT_BASE+idx arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
//   dut_busy already 1 when RUN entered: dut_run asserts for exactly one cycle.
//   host_in_valid is ignored outside IDLE/LOAD.
//   Reset mid-job: dut_run and all strobes drop immediately; the partial job is discarded.
// CONFIGURATION
//   LOADER_TIMEOUT_EN defined: a cycle counter runs in RUN and WAIT_DONE.
//     On reaching TIMEOUT_CYC it forces FINISH, pulses job_done, and sets sticky output port
//     timeout_err (1 bit, cleared on next job start). No results are streamed.
//   LOADER_TIMEOUT_EN not defined: no counter and no timeout_err port; waits indefinitely.
// TESTING
//   Load [4,8,0x1234,0x5678,last] -> writes addr0..3 data 4,8,0x1234,0x5678; dut_run rises next cycle.
//   DUT model: busy 2 cycles after run, 20 cycles long -> dut_run high exactly until busy seen; RD_ADDR=0x800 after busy falls.
//   result_count=3, out_ready=1, SRAM 0x800..0x802=A,B,C -> out A,B,C, last on C, job_done next cycle.
//   out_ready low 5 cycles on word B -> B held stable; no skip or duplicate.
//   Load 2050 words -> load_overflow=1, no write above 0x7FF, job still runs.
//   Reset asserted in WAIT_DONE -> all outputs 0 same cycle; next job completes normally.
//   LOADER_TIMEOUT_EN, TIMEOUT_CYC=100, busy never rises -> timeout_err=1, job_done pulse at cycle 100.

Source files
------------

// File: rtl/sram_load_sequencer.sv
// Host-side loader: streams a job image into input SRAM, runs the DUT, then returns results.
// Optional watchdog on the run/wait phase is built when LOADER_TIMEOUT_EN is defined.
module sram_load_sequencer #(
   parameter int                ADDR_W      = 12,
   parameter int                DATA_W      = 16,
   parameter logic [ADDR_W-1:0] RESULT_BASE = 12'h800,
   parameter logic [ADDR_W-1:0] LOAD_MAX    = 12'h7FF
`ifdef LOADER_TIMEOUT_EN
   ,
   parameter int                TIMEOUT_CYC = 65535
`endif
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              host_in_valid,
   output logic              host_in_ready,
   input  logic [DATA_W-1:0] host_in_data,
   input  logic              host_in_last,
   input  logic [ADDR_W-1:0] result_count,
   output logic [ADDR_W-1:0] ld_sram_write_address,
   output logic [DATA_W-1:0] ld_sram_write_data,
   output logic              ld_sram_write_enable,
   output logic              dut_run,
   input  logic              dut_busy,
   output logic [ADDR_W-1:0] ld_sram_read_address,
   input  logic [DATA_W-1:0] sram_ld_read_data,
   output logic              host_out_valid,
   input  logic              host_out_ready,
   output logic [DATA_W-1:0] host_out_data,
   output logic              host_out_last,
   output logic              job_done,
   output logic              load_overflow
`ifdef LOADER_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   // state     | meaning
   // IDLE      | waiting for first load beat (written to address 0)
   // LOAD      | accepting load beats until host_in_last
   // RUN       | dut_run held until dut_busy seen
   // WAIT_DONE | waiting for dut_busy to fall
   // RD_ADDR   | result read address presented to SRAM
   // RD_DATA   | SRAM data valid, captured into output register
   // OUT_HOLD  | result word held until host accepts it
   // FINISH    | job_done pulse
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_RUN       = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_RD_ADDR   = 3'd4;
   localparam logic [2:0] S_RD_DATA   = 3'd5;
   localparam logic [2:0] S_OUT_HOLD  = 3'd6;
   localparam logic [2:0] S_FINISH    = 3'd7;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W:0]   load_ptr;
   logic [ADDR_W-1:0] count_q;
   logic [ADDR_W-1:0] idx;
   logic              in_fire;
   logic              last_word;
   logic              tmo_hit;

   assign in_fire   = host_in_valid & host_in_ready;
   assign last_word = (idx == count_q - ADDR_W'(1));

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             in_run_phase;

   assign in_run_phase = (state == S_RUN) || (state == S_WAIT_DONE);
   assign tmo_hit      = in_run_phase && (tmo_cnt == '0);

   // Down-counter armed on RUN entry; terminal count forces the job to finish.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if ((state_nxt == S_RUN) && (state != S_RUN))
            tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
         else if (in_run_phase && (tmo_cnt != '0))
            tmo_cnt <= tmo_cnt - TMO_W'(1);
         if (in_fire && (state == S_IDLE))
            timeout_err <= 1'b0;
         else if (tmo_hit)
            timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (in_fire) state_nxt = host_in_last ? S_RUN : S_LOAD;
         S_LOAD:      if (in_fire && host_in_last) state_nxt = S_RUN;
         S_RUN:       if (dut_busy) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (!dut_busy) state_nxt = (count_q == '0) ? S_FINISH : S_RD_ADDR;
         S_RD_ADDR:   state_nxt = S_RD_DATA;
         S_RD_DATA:   state_nxt = S_OUT_HOLD;
         S_OUT_HOLD:  if (host_out_ready) state_nxt = last_word ? S_FINISH : S_RD_ADDR;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
      if (tmo_hit) state_nxt = S_FINISH;
   end

   // Handshake/strobe outputs are registered from the next state so they are glitch-free
   // and all read 0 while reset is held.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state                 <= S_IDLE;
         host_in_ready         <= 1'b0;
         dut_run               <= 1'b0;
         job_done              <= 1'b0;
         ld_sram_write_enable  <= 1'b0;
         ld_sram_write_address <= '0;
         ld_sram_write_data    <= '0;
         load_ptr              <= '0;
         count_q               <= '0;
         load_overflow         <= 1'b0;
      end else begin
         state                <= state_nxt;
         host_in_ready        <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
         dut_run              <= (state_nxt == S_RUN);
         job_done             <= (state_nxt == S_FINISH);
         ld_sram_write_enable <= 1'b0;
         if (in_fire) begin
            if (state == S_IDLE) begin
               ld_sram_write_address <= '0;
               ld_sram_write_data    <= host_in_data;
               ld_sram_write_enable  <= 1'b1;
               load_ptr              <= (ADDR_W+1)'(1);
               count_q               <= result_count;
               load_overflow         <= 1'b0;
            end else if (load_ptr > {1'b0, LOAD_MAX}) begin
               // Past the input window: drop the word, pointer parks.
               load_overflow <= 1'b1;
            end else begin
               ld_sram_write_address <= load_ptr[ADDR_W-1:0];
               ld_sram_write_data    <= host_in_data;
               ld_sram_write_enable  <= 1'b1;
               load_ptr              <= load_ptr + (ADDR_W+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         idx                  <= '0;
         ld_sram_read_address <= '0;
         host_out_valid       <= 1'b0;
         host_out_data        <= '0;
         host_out_last        <= 1'b0;
      end else begin
         case (state)
            S_WAIT_DONE: begin
               if (state_nxt == S_RD_ADDR) begin
                  idx                  <= '0;
                  ld_sram_read_address <= RESULT_BASE;
               end
            end
            S_RD_DATA: begin
               host_out_data  <= sram_ld_read_data;
               host_out_valid <= 1'b1;
               host_out_last  <= last_word;
            end
            S_OUT_HOLD: begin
               if (host_out_ready) begin
                  host_out_valid       <= 1'b0;
                  host_out_last        <= 1'b0;
                  idx                  <= idx + ADDR_W'(1);
                  ld_sram_read_address <= RESULT_BASE + idx + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
